// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
//
// Read-side consumer for the synchronous FIFO (one-cycle registered read).
// Pops DATA_WIDTH words and packs PACK of them into one OUT_WIDTH beat on a
// valid/ready stream. Lane 0 (bits [DATA_WIDTH-1:0]) holds the oldest word.
// A single-cycle flush emits any partial beat with per-lane keep flags.
//
// Optional feature macro: FIFO_RD_PACKER_STATS_EN
//   defined   : stat_words / stat_beats are saturating 32-bit counters
//   undefined : stat_words / stat_beats are tied to zero, no counter flops
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous, active-high reset
//   fifo_empty     in   FIFO empty flag
//   fifo_rd_en     out  FIFO pop request (combinational from registered state)
//   fifo_data_out  in   FIFO read data, valid the cycle after fifo_rd_en
//   flush          in   single-cycle request to emit any partial beat
//   m_valid        out  output beat valid
//   m_ready        in   downstream accept
//   m_data         out  packed beat
//   m_keep         out  per-lane valid flags
//   flush_done     out  one-cycle pulse when a flush completes
//   stat_words     out  words popped (optional)
//   stat_beats     out  beats accepted (optional)
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int OUT_WIDTH  = DATA_WIDTH * PACK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic [PACK-1:0]       m_keep,
    output logic                  flush_done,
    output logic [31:0]           stat_words,
    output logic [31:0]           stat_beats
);

    localparam int               CNT_W      = $clog2(PACK + 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(PACK);
    localparam logic [CNT_W:0]   CNT_FULL_X = (CNT_W + 1)'(PACK);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;

    generate
        if (PACK < 2 || OUT_WIDTH != DATA_WIDTH * PACK) begin : g_bad_params
            $error("fifo_rd_packer: PACK must be >= 2 and OUT_WIDTH must equal DATA_WIDTH*PACK");
        end
    endgenerate

    logic [1:0]                      state_q,      state_d;
    logic [CNT_W-1:0]                acc_cnt_q,    acc_cnt_d;
    logic                            inflight_q,   inflight_d;
    logic [PACK-1:0][DATA_WIDTH-1:0] acc_q,        acc_d;
    logic                            m_valid_q,    m_valid_d;
    logic [OUT_WIDTH-1:0]            m_data_q,     m_data_d;
    logic [PACK-1:0]                 m_keep_q,     m_keep_d;
    logic                            flush_done_q, flush_done_d;

    logic                            out_free;
    logic [CNT_W:0]                  occupancy;

    // Output register can take a new beat when it is empty or being accepted.
    assign out_free  = !m_valid_q || m_ready;

    // Words already captured plus the one still arriving; one bit wider so the
    // sum cannot wrap. Keeping it below PACK guarantees the accumulator never
    // overflows.
    assign occupancy = {1'b0, acc_cnt_q} + {{CNT_W{1'b0}}, inflight_q};

    assign fifo_rd_en = !rst && (state_q == ST_FILL) && !fifo_empty &&
                        (occupancy < CNT_FULL_X);

    always_comb begin
        state_d      = state_q;
        acc_cnt_d    = acc_cnt_q;
        acc_d        = acc_q;
        inflight_d   = fifo_rd_en;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        flush_done_d = 1'b0;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        // Capture the word requested last cycle into the next free lane.
        // Cannot coincide with a transfer: a full accumulator implies no read
        // was in flight.
        if (inflight_q) begin
            for (int i = 0; i < PACK; i++) begin
                if (acc_cnt_q == CNT_W'(i)) begin
                    acc_d[i] = fifo_data_out;
                end
            end
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_FILL: begin
                if (acc_cnt_q == CNT_FULL && out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = acc_q;
                    m_keep_d  = '1;
                    acc_d     = '0;
                    acc_cnt_d = '0;
                end
                if (flush) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Reads stopped on entry; wait until the last requested word
                // has landed before deciding whether anything is left to emit.
                if (!inflight_q) begin
                    if (acc_cnt_q == '0) begin
                        flush_done_d = 1'b1;
                        state_d      = ST_FILL;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end
            end

            ST_EMIT: begin
                // Unused lanes are already zero because the accumulator is
                // cleared on every load and on reset.
                if (out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = acc_q;
                    for (int i = 0; i < PACK; i++) begin
                        m_keep_d[i] = (CNT_W'(i) < acc_cnt_q);
                    end
                    acc_d        = '0;
                    acc_cnt_d    = '0;
                    flush_done_d = 1'b1;
                    state_d      = ST_FILL;
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FILL;
            acc_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            acc_q        <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            inflight_q   <= inflight_d;
            acc_q        <= acc_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_keep     = m_keep_q;
    assign flush_done = flush_done_q;

`ifdef FIFO_RD_PACKER_STATS_EN
    logic [31:0] stat_words_q, stat_words_d;
    logic [31:0] stat_beats_q, stat_beats_d;

    // Saturating counters: they stick at all-ones rather than wrapping.
    always_comb begin
        stat_words_d = stat_words_q;
        stat_beats_d = stat_beats_q;
        if (fifo_rd_en && (stat_words_q != 32'hFFFF_FFFF)) begin
            stat_words_d = stat_words_q + 32'd1;
        end
        if (m_valid_q && m_ready && (stat_beats_q != 32'hFFFF_FFFF)) begin
            stat_beats_d = stat_beats_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words_q <= '0;
            stat_beats_q <= '0;
        end else begin
            stat_words_q <= stat_words_d;
            stat_beats_q <= stat_beats_d;
        end
    end

    assign stat_words = stat_words_q;
    assign stat_beats = stat_beats_q;
`else
    assign stat_words = '0;
    assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int PK = 4;
    localparam int OW = DW * PK;

`ifdef FIFO_RD_PACKER_STATS_EN
    localparam logic [31:0] EXP_STAT_WORDS = 32'd12;
    localparam logic [31:0] EXP_STAT_BEATS = 32'd3;
`else
    localparam logic [31:0] EXP_STAT_WORDS = 32'd0;
    localparam logic [31:0] EXP_STAT_BEATS = 32'd0;
`endif

    logic          clk;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data_out;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] m_data;
    logic [PK-1:0] m_keep;
    logic          flush_done;
    logic [31:0]   stat_words;
    logic [31:0]   stat_beats;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Behavioural FIFO contents and the expected word stream for the scoreboard.
    logic [7:0] fifo_q[$];
    logic [7:0] ew[$];

    // Values observed at the falling edge of the most recent cycle.
    logic          obs_valid, obs_ready, obs_acc, obs_fd, obs_rd;
    logic [OW-1:0] obs_data;
    logic [PK-1:0] obs_keep;

    fifo_rd_packer #(
        .DATA_WIDTH (DW),
        .PACK       (PK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_data_out (fifo_data_out),
        .flush         (flush),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_keep        (m_keep),
        .flush_done    (flush_done),
        .stat_words    (stat_words),
        .stat_beats    (stat_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    // One clock cycle: sample outputs mid-cycle, then model the FIFO's
    // registered read just after the rising edge.
    task automatic tick();
        logic pop;
        @(negedge clk);
        pop       = fifo_rd_en;
        obs_valid = m_valid;
        obs_ready = m_ready;
        obs_acc   = m_valid && m_ready;
        obs_data  = m_data;
        obs_keep  = m_keep;
        obs_fd    = flush_done;
        obs_rd    = fifo_rd_en;
        if (pop === 1'b1) begin
            vectors++;
            if (fifo_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_empty: fifo_rd_en=1 with FIFO empty, required 0");
                pop = 1'b0;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (pop === 1'b1) fifo_data_out = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        m_ready = 1'b0;
        flush   = 1'b0;
        fifo_q.delete();
        fifo_empty = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_accept(input int max_cyc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            tick();
            if (obs_acc === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; m_ready = 1'b1;
        push(8'h5A);
        tick();
        tick();
        vectors++; if (obs_rd !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b want 0", obs_rd); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        vectors++; if (m_data !== '0) begin miscompares++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        vectors++; if (m_keep !== '0) begin miscompares++; $display("FAIL reset_m_keep: got %h want 0", m_keep); end
        vectors++; if (flush_done !== 1'b0) begin miscompares++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
        vectors++; if (stat_words !== 32'd0) begin miscompares++; $display("FAIL reset_stat_words: got %0d want 0", stat_words); end
        vectors++; if (stat_beats !== 32'd0) begin miscompares++; $display("FAIL reset_stat_beats: got %0d want 0", stat_beats); end
        fifo_q.delete();
        fifo_empty = 1'b1;
        rst = 1'b0;
    endtask

    task automatic test_single_beat();
        logic ok;
        do_reset();
        m_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_accept(30, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL single_timeout: no beat accepted within 30 cycles"); end
        vectors++; if (obs_data !== 32'h44332211) begin miscompares++; $display("FAIL single_data: got %h want 44332211", obs_data); end
        vectors++; if (obs_keep !== 4'hF) begin miscompares++; $display("FAIL single_keep: got %h want f", obs_keep); end
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++; if (obs_rd !== 1'b0) begin miscompares++; $display("FAIL single_rd_idle: got %b want 0", obs_rd); end
            vectors++; if (obs_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_drop: got %b want 0", obs_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w[8];
        logic       ok;
        int         c1;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w[i] = 8'($urandom);
            push(w[i]);
        end
        wait_accept(30, ok);
        c1 = cyc;
        vectors++; if (ok !== 1'b1 || obs_data !== pack4(w[0], w[1], w[2], w[3]))
            begin miscompares++; $display("FAIL b2b_beat0: got %h want %h", obs_data, pack4(w[0], w[1], w[2], w[3])); end
        wait_accept(30, ok);
        vectors++; if (ok !== 1'b1 || obs_data !== pack4(w[4], w[5], w[6], w[7]))
            begin miscompares++; $display("FAIL b2b_beat1: got %h want %h", obs_data, pack4(w[4], w[5], w[6], w[7])); end
        vectors++; if (cyc - c1 != PK + 2) begin miscompares++; $display("FAIL b2b_throughput: beat gap %0d cycles want %0d", cyc - c1, PK + 2); end
    endtask

    task automatic test_backpressure();
        logic [7:0]    w[8];
        logic          ok;
        logic [OW-1:0] first;
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w[i] = 8'($urandom);
            push(w[i]);
        end
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            if (obs_valid === 1'b1) ok = 1'b1;
        end
        first = obs_data;
        vectors++; if (ok !== 1'b1 || first !== pack4(w[0], w[1], w[2], w[3]))
            begin miscompares++; $display("FAIL bp_first: got %h want %h", first, pack4(w[0], w[1], w[2], w[3])); end
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++; if (obs_valid !== 1'b1 || obs_data !== first || obs_keep !== 4'hF)
                begin miscompares++; $display("FAIL bp_hold: valid=%b data=%h keep=%h want 1/%h/f", obs_valid, obs_data, obs_keep, first); end
        end
        vectors++; if (fifo_q.size() != 0) begin miscompares++; $display("FAIL bp_words_popped: %0d left in FIFO want 0", fifo_q.size()); end
        vectors++; if (obs_rd !== 1'b0) begin miscompares++; $display("FAIL bp_rd_stopped: got %b want 0", obs_rd); end
        m_ready = 1'b1;
        tick();
        vectors++; if (obs_acc !== 1'b1 || obs_data !== pack4(w[0], w[1], w[2], w[3]))
            begin miscompares++; $display("FAIL bp_accept0: acc=%b data=%h want 1/%h", obs_acc, obs_data, pack4(w[0], w[1], w[2], w[3])); end
        tick();
        vectors++; if (obs_acc !== 1'b1 || obs_data !== pack4(w[4], w[5], w[6], w[7]))
            begin miscompares++; $display("FAIL bp_accept1: acc=%b data=%h want 1/%h", obs_acc, obs_data, pack4(w[4], w[5], w[6], w[7])); end
        tick();
        vectors++; if (obs_valid !== 1'b0) begin miscompares++; $display("FAIL bp_idle: valid=%b want 0", obs_valid); end
    endtask

    task automatic test_flush_partial();
        int   fd_cnt;
        logic seen;
        do_reset();
        m_ready = 1'b1;
        push(8'hA1); push(8'hA2);
        repeat (6) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fd_cnt = 0;
        seen   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_fd === 1'b1) fd_cnt++;
            if (obs_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                vectors++; if (obs_data !== 32'h0000A2A1) begin miscompares++; $display("FAIL flush_data: got %h want 0000a2a1", obs_data); end
                vectors++; if (obs_keep !== 4'h3) begin miscompares++; $display("FAIL flush_keep: got %h want 3", obs_keep); end
                vectors++; if (obs_fd !== 1'b1) begin miscompares++; $display("FAIL flush_done_align: got %b want 1", obs_fd); end
            end
        end
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL flush_no_beat: got 0 beats want 1"); end
        vectors++; if (fd_cnt != 1) begin miscompares++; $display("FAIL flush_done_count: got %0d want 1", fd_cnt); end
    endtask

    task automatic test_flush_empty();
        logic exp_fd[4];
        exp_fd[0] = 1'b0; exp_fd[1] = 1'b0; exp_fd[2] = 1'b1; exp_fd[3] = 1'b0;
        do_reset();
        m_ready = 1'b1;
        tick();
        flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            flush = 1'b0;
            vectors++; if (obs_fd !== exp_fd[i]) begin miscompares++; $display("FAIL flush_empty_fd%0d: got %b want %b", i, obs_fd, exp_fd[i]); end
            vectors++; if (obs_valid !== 1'b0) begin miscompares++; $display("FAIL flush_empty_valid%0d: got %b want 0", i, obs_valid); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] n[4];
        logic       ok;
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) push(8'($urandom_range(1, 255)));
        repeat (20) tick();
        vectors++; if (obs_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_valid: got %b want 1", obs_valid); end
        rst = 1'b1;
        tick();
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b want 0", m_valid); end
        vectors++; if (m_data !== '0) begin miscompares++; $display("FAIL rstmid_data: got %h want 0", m_data); end
        vectors++; if (m_keep !== '0) begin miscompares++; $display("FAIL rstmid_keep: got %h want 0", m_keep); end
        vectors++; if (flush_done !== 1'b0) begin miscompares++; $display("FAIL rstmid_fd: got %b want 0", flush_done); end
        rst     = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n[i] = 8'($urandom);
            push(n[i]);
        end
        wait_accept(30, ok);
        vectors++; if (ok !== 1'b1 || obs_data !== pack4(n[0], n[1], n[2], n[3]) || obs_keep !== 4'hF)
            begin miscompares++; $display("FAIL rstmid_fresh: data=%h keep=%h want %h/f", obs_data, obs_keep, pack4(n[0], n[1], n[2], n[3])); end
    endtask

    task automatic test_stats();
        int acc_cnt;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) push(8'($urandom));
        acc_cnt = 0;
        for (int i = 0; i < 80 && acc_cnt < 3; i++) begin
            tick();
            if (obs_acc === 1'b1) acc_cnt++;
        end
        tick();
        tick();
        vectors++; if (acc_cnt != 3) begin miscompares++; $display("FAIL stats_beats_seen: got %0d want 3", acc_cnt); end
        vectors++; if (stat_words !== EXP_STAT_WORDS) begin miscompares++; $display("FAIL stat_words: got %0d want %0d", stat_words, EXP_STAT_WORDS); end
        vectors++; if (stat_beats !== EXP_STAT_BEATS) begin miscompares++; $display("FAIL stat_beats: got %0d want %0d", stat_beats, EXP_STAT_BEATS); end
    endtask

    task automatic test_random();
        logic          pv, pr;
        logic [OW-1:0] pd, exp;
        logic [PK-1:0] pk, exp_keep;
        logic [7:0]    b;
        int            n, seen, fd_cnt;
        do_reset();
        ew.delete();
        pv = 1'b0; pr = 1'b0; pd = '0; pk = '0;
        for (int c = 0; c < 440; c++) begin
            if (c < 400) begin
                if (fifo_q.size() < 6 && $urandom_range(0, 1) == 1) begin
                    b = 8'($urandom);
                    push(b);
                    ew.push_back(b);
                end
                m_ready = ($urandom_range(0, 2) != 0);
            end else begin
                m_ready = 1'b1;
            end
            tick();
            if (pv === 1'b1 && pr !== 1'b1) begin
                vectors++;
                if (obs_valid !== 1'b1 || obs_data !== pd || obs_keep !== pk)
                    begin miscompares++; $display("FAIL rnd_stall: valid=%b data=%h keep=%h want 1/%h/%h", obs_valid, obs_data, obs_keep, pd, pk); end
            end
            if (obs_acc === 1'b1) begin
                vectors++;
                if (ew.size() < PK) begin
                    miscompares++; $display("FAIL rnd_extra_beat: data=%h with only %0d words pending", obs_data, ew.size());
                end else begin
                    exp = pack4(ew[0], ew[1], ew[2], ew[3]);
                    repeat (PK) void'(ew.pop_front());
                    if (obs_data !== exp || obs_keep !== 4'hF)
                        begin miscompares++; $display("FAIL rnd_beat: data=%h keep=%h want %h/f", obs_data, obs_keep, exp); end
                end
            end
            pv = obs_valid; pr = obs_ready; pd = obs_data; pk = obs_keep;
        end
        vectors++; if (ew.size() >= PK) begin miscompares++; $display("FAIL rnd_leftover: %0d words pending want < %0d", ew.size(), PK); end
        n = ew.size();
        exp = '0;
        for (int i = 0; i < n && i < PK; i++) exp = exp | (32'(ew[i]) << (8 * i));
        exp_keep = 4'((1 << n) - 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen = 0;
        fd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_fd === 1'b1) fd_cnt++;
            if (obs_acc === 1'b1) begin
                seen++;
                vectors++;
                if (obs_data !== exp || obs_keep !== exp_keep)
                    begin miscompares++; $display("FAIL rnd_flush_beat: data=%h keep=%h want %h/%h", obs_data, obs_keep, exp, exp_keep); end
            end
        end
        vectors++; if (seen != ((n > 0) ? 1 : 0)) begin miscompares++; $display("FAIL rnd_flush_count: got %0d beats want %0d", seen, (n > 0) ? 1 : 0); end
        vectors++; if (fd_cnt != 1) begin miscompares++; $display("FAIL rnd_flush_done: got %0d pulses want 1", fd_cnt); end
    endtask

    initial begin
        rst           = 1'b1;
        fifo_empty    = 1'b1;
        fifo_data_out = '0;
        flush         = 1'b0;
        m_ready       = 1'b0;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_backpressure();
        test_flush_partial();
        test_flush_empty();
        test_reset_mid();
        test_stats();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
